// File: rtl/sb_mac16_pkg.sv
// sb_mac16_pkg -- select encodings and helpers shared by the MAC16 core.
// Encodings are 2-bit per adder half unless noted; the upper-operand select
// is a single bit per half.
package sb_mac16_pkg;

  // Upper adder operand (one bit per half)
  localparam logic       UPPER_Q       = 1'b0;  // accumulator register
  localparam logic       UPPER_CD      = 1'b1;  // C (top) / D (bottom)

  // Lower adder operand
  localparam logic [1:0] LOWER_AB      = 2'b00; // A (top) / B (bottom)
  localparam logic [1:0] LOWER_8X8     = 2'b01; // F (top) / G (bottom)
  localparam logic [1:0] LOWER_P       = 2'b10; // P high / P low
  localparam logic [1:0] LOWER_ZERO    = 2'b11;

  // Carry-in source
  localparam logic [1:0] CARRY_ZERO    = 2'b00;
  localparam logic [1:0] CARRY_ONE     = 2'b01;
  localparam logic [1:0] CARRY_CASCADE = 2'b10; // top only: bottom carry-out
  localparam logic [1:0] CARRY_CI      = 2'b11; // bottom treats 1x as ci

  // Output half source
  localparam logic [1:0] OUT_SUM       = 2'b00;
  localparam logic [1:0] OUT_Q         = 2'b01;
  localparam logic [1:0] OUT_8X8       = 2'b10;
  localparam logic [1:0] OUT_P         = 2'b11;

  // Widen a 16-bit operand to 32 bits, sign- or zero-extending.
  function automatic logic [31:0] ext16(input logic [15:0] v, input logic is_signed);
    return {{16{is_signed & v[15]}}, v};
  endfunction

endpackage

// File: rtl/mac16_addsub16.sv
// mac16_addsub16 -- 16-bit adder/subtractor with carry-in and carry-out.
// In subtract mode cin acts as borrow-in and cout reports borrow-out.
module mac16_addsub16 (
  input  logic        sub,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] res;

  // 17-bit result: bit 16 is carry on add and borrow on subtract
  always_comb begin
    if (sub) res = {1'b0, x} - {1'b0, y} - {16'd0, cin};
    else     res = {1'b0, x} + {1'b0, y} + {16'd0, cin};
  end

  assign sum  = res[15:0];
  assign cout = res[16];

endmodule

// File: rtl/sb_mac16_core.sv
// sb_mac16_core -- 16x16 multiply / dual 16-bit add-accumulate core.
// Optional feature: define MAC16_MODE8X8_EN to build the dual 8x8
// multipliers (F/G); without it F and G read as zero.
module sb_mac16_core
  import sb_mac16_pkg::*;
#(
  parameter logic [1:0] SIGNED        = 2'b00,
  parameter logic [3:0] IN_REG        = 4'b0000,
  parameter logic       MULT_REG      = 1'b0,
  parameter logic       MODE_8X8      = 1'b0,
  parameter logic [1:0] UPPERINPUT    = 2'b00,
  parameter logic [3:0] LOWERINPUT    = 4'b0000,
  parameter logic [3:0] CARRYSELECT   = 4'b0000,
  parameter logic [3:0] OUTPUT_SELECT = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [3:0]  ihold,
  input  logic [1:0]  ohold,
  input  logic [1:0]  oload,
  input  logic [1:0]  addsub,
  input  logic        ci,
  output logic        co,
  output logic [31:0] o
);

  // Operands indexed 3..0 = A,B,C,D to match IN_REG/ihold bit order
  logic [15:0] in_raw [4];
  logic [15:0] in_q   [4];

  assign in_raw[3] = a;
  assign in_raw[2] = b;
  assign in_raw[1] = c;
  assign in_raw[0] = d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_in
    if (IN_REG[gi]) begin : g_reg
      logic [15:0] op_reg;
      // optional operand register, frozen while its hold bit is set
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                    op_reg <= '0;
        else if (ce && !ihold[gi])  op_reg <= in_raw[gi];
      end
      assign in_q[gi] = op_reg;
    end else begin : g_comb
      assign in_q[gi] = in_raw[gi];
    end
  end

  // Multipliers
  logic [31:0] p_comb;
  logic [15:0] f_comb;
  logic [15:0] g_comb;

  assign p_comb = ext16(in_q[3], SIGNED[1]) * ext16(in_q[2], SIGNED[0]);

`ifdef MAC16_MODE8X8_EN
  assign f_comb = MODE_8X8 ? ({8'd0, in_q[3][15:8]} * {8'd0, in_q[2][15:8]}) : 16'd0;
  assign g_comb = MODE_8X8 ? ({8'd0, in_q[3][7:0]}  * {8'd0, in_q[2][7:0]})  : 16'd0;
`else
  assign f_comb = 16'd0;
  assign g_comb = 16'd0;
`endif

  logic [31:0] p_q;
  logic [15:0] f_q;
  logic [15:0] g_q;

  if (MULT_REG) begin : g_mreg
    logic [31:0] p_reg;
    logic [15:0] f_reg;
    logic [15:0] g_reg;
    // product pipeline stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p_reg <= '0;
        f_reg <= '0;
        g_reg <= '0;
      end else if (ce) begin
        p_reg <= p_comb;
        f_reg <= f_comb;
        g_reg <= g_comb;
      end
    end
    assign p_q = p_reg;
    assign f_q = f_reg;
    assign g_q = g_reg;
  end else begin : g_mcomb
    assign p_q = p_comb;
    assign f_q = f_comb;
    assign g_q = g_comb;
  end

  // Adder operand and carry selection
  logic [15:0] q_top_reg, q_bot_reg;
  logic [15:0] x_top, y_top, x_bot, y_bot;
  logic [15:0] sum_top, sum_bot;
  logic        cin_top, cin_bot, co_top, co_bot;

  // upper operands: accumulator or C/D
  always_comb begin
    x_top = (UPPERINPUT[1] == UPPER_CD) ? in_q[1] : q_top_reg;
    x_bot = (UPPERINPUT[0] == UPPER_CD) ? in_q[0] : q_bot_reg;
  end

  // lower operands: raw operand, 8x8 product, 16x16 product half or zero
  always_comb begin
    case (LOWERINPUT[3:2])
      LOWER_AB:  y_top = in_q[3];
      LOWER_8X8: y_top = f_q;
      LOWER_P:   y_top = p_q[31:16];
      default:   y_top = 16'd0;
    endcase
    case (LOWERINPUT[1:0])
      LOWER_AB:  y_bot = in_q[2];
      LOWER_8X8: y_bot = g_q;
      LOWER_P:   y_bot = p_q[15:0];
      default:   y_bot = 16'd0;
    endcase
  end

  // carry-ins; the top half may chain from the bottom half's carry-out
  always_comb begin
    case (CARRYSELECT[3:2])
      CARRY_ZERO:    cin_top = 1'b0;
      CARRY_ONE:     cin_top = 1'b1;
      CARRY_CASCADE: cin_top = co_bot;
      default:       cin_top = ci;
    endcase
    case (CARRYSELECT[1:0])
      CARRY_ZERO: cin_bot = 1'b0;
      CARRY_ONE:  cin_bot = 1'b1;
      default:    cin_bot = ci;
    endcase
  end

  mac16_addsub16 u_add_bot (
    .sub  (addsub[0]),
    .x    (x_bot),
    .y    (y_bot),
    .cin  (cin_bot),
    .sum  (sum_bot),
    .cout (co_bot)
  );

  mac16_addsub16 u_add_top (
    .sub  (addsub[1]),
    .x    (x_top),
    .y    (y_top),
    .cin  (cin_top),
    .sum  (sum_top),
    .cout (co_top)
  );

  // accumulators: hold beats load, load beats the adder sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_top_reg <= '0;
      q_bot_reg <= '0;
    end else if (ce) begin
      if (!ohold[1]) q_top_reg <= oload[1] ? in_q[1] : sum_top;
      if (!ohold[0]) q_bot_reg <= oload[0] ? in_q[0] : sum_bot;
    end
  end

  // output half sources
  always_comb begin
    case (OUTPUT_SELECT[3:2])
      OUT_SUM: o[31:16] = sum_top;
      OUT_Q:   o[31:16] = q_top_reg;
      OUT_8X8: o[31:16] = f_q;
      default: o[31:16] = p_q[31:16];
    endcase
    case (OUTPUT_SELECT[1:0])
      OUT_SUM: o[15:0] = sum_bot;
      OUT_Q:   o[15:0] = q_bot_reg;
      OUT_8X8: o[15:0] = g_q;
      default: o[15:0] = p_q[15:0];
    endcase
  end

  assign co = co_top;

  // hold bits and the 8x8 mode flag are dead in some configurations
  logic unused_cfg;
  assign unused_cfg = ^{ihold, MODE_8X8};

endmodule

// File: tb/tb_sb_mac16_core.sv
// tb_sb_mac16_core -- table-driven and scoreboard checks for sb_mac16_core.
module tb_sb_mac16_core;

  logic        clk, rst, ce, ci;
  logic [15:0] a, b, c, d;
  logic [3:0]  ihold;
  logic [1:0]  ohold, oload, addsub;

  logic [31:0] o_comb, o_mu, o_ms, o_acc, o_reg;
  logic        co_comb, co_mu, co_ms, co_acc, co_reg;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a, b, c, d;
    logic [1:0]  addsub;
    logic [31:0] exp_o;
    logic        exp_co;
  } vec_t;

  typedef struct {
    logic [31:0] o;
    logic        co;
  } exp_t;

  vec_t vecs [8];
  exp_t sb_q [$];

  // Adder-only: C/D upper, A/B lower, carry cascade, sum out
  sb_mac16_core #(.UPPERINPUT(2'b11), .LOWERINPUT(4'b0000), .CARRYSELECT(4'b1000),
                  .OUTPUT_SELECT(4'b0000)) dut_comb (
    .clk(clk), .rst(rst), .ce(ce), .a(a), .b(b), .c(c), .d(d), .ihold(ihold),
    .ohold(ohold), .oload(oload), .addsub(addsub), .ci(ci), .co(co_comb), .o(o_comb));

  // Unsigned multiply through the adders
  sb_mac16_core #(.SIGNED(2'b00), .UPPERINPUT(2'b11), .LOWERINPUT(4'b1010)) dut_mu (
    .clk(clk), .rst(rst), .ce(ce), .a(a), .b(b), .c(c), .d(d), .ihold(ihold),
    .ohold(ohold), .oload(oload), .addsub(addsub), .ci(ci), .co(co_mu), .o(o_mu));

  // Signed multiply through the adders
  sb_mac16_core #(.SIGNED(2'b11), .UPPERINPUT(2'b11), .LOWERINPUT(4'b1010)) dut_ms (
    .clk(clk), .rst(rst), .ce(ce), .a(a), .b(b), .c(c), .d(d), .ihold(ihold),
    .ohold(ohold), .oload(oload), .addsub(addsub), .ci(ci), .co(co_ms), .o(o_ms));

  // Multiply-accumulate, Q on the output
  sb_mac16_core #(.UPPERINPUT(2'b00), .LOWERINPUT(4'b1010), .CARRYSELECT(4'b1000),
                  .OUTPUT_SELECT(4'b0101)) dut_acc (
    .clk(clk), .rst(rst), .ce(ce), .a(a), .b(b), .c(c), .d(d), .ihold(ihold),
    .ohold(ohold), .oload(oload), .addsub(addsub), .ci(ci), .co(co_acc), .o(o_acc));

  // Registered inputs and product, P on the output (2-cycle latency)
  sb_mac16_core #(.IN_REG(4'b1111), .MULT_REG(1'b1), .OUTPUT_SELECT(4'b1111)) dut_reg (
    .clk(clk), .rst(rst), .ce(ce), .a(a), .b(b), .c(c), .d(d), .ihold(ihold),
    .ohold(ohold), .oload(oload), .addsub(addsub), .ci(ci), .co(co_reg), .o(o_reg));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a_mdl, b_mdl, exp_p;
    logic [1:0]  ih;
    exp_t        e;

    vecs[0] = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0001, 2'b00, 32'h00020000, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 16'h0001, 16'h0000, 2'b11, 32'h0000FFFF, 1'b0};
    vecs[2] = '{16'h1234, 16'h1111, 16'h1000, 16'h2222, 2'b00, 32'h22343333, 1'b0};
    vecs[3] = '{16'h8000, 16'h0000, 16'h8000, 16'h0000, 2'b00, 32'h00000000, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 2'b00, 32'h00000000, 1'b1};
    vecs[5] = '{16'h0002, 16'h0000, 16'h0001, 16'h0005, 2'b11, 32'hFFFF0005, 1'b1};
    vecs[6] = '{16'h0003, 16'h0004, 16'h0010, 16'hFFFE, 2'b10, 32'h000C0002, 1'b0};
    vecs[7] = '{16'h0001, 16'h0001, 16'h0005, 16'h0000, 2'b01, 32'h0007FFFF, 1'b0};

    rst = 1'b1; ce = 1'b0; ci = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    ihold = '0; ohold = '0; oload = '0; addsub = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_acc_o", o_acc, 32'h0);
    check("reset_reg_o", o_reg, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational adder table
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].a; b = vecs[i].b; c = vecs[i].c; d = vecs[i].d;
      addsub = vecs[i].addsub;
      sb_q.push_back('{vecs[i].exp_o, vecs[i].exp_co});
      #1;
      e = sb_q.pop_front();
      check($sformatf("add_vec%0d_o", i), o_comb, e.o);
      check($sformatf("add_vec%0d_co", i), {31'd0, co_comb}, {31'd0, e.co});
    end
    addsub = 2'b00;

    // Multiplier, unsigned and signed
    a = 16'hFFFF; b = 16'hFFFF; c = '0; d = '0;
    #1;
    check("mul_u_ffff_ffff", o_mu, 32'hFFFE0001);
    check("mul_s_ffff_ffff", o_ms, 32'h00000001);
    b = 16'h0002;
    #1;
    check("mul_u_ffff_0002", o_mu, 32'h0001FFFE);
    check("mul_s_ffff_0002", o_ms, 32'hFFFFFFFE);

    // Accumulate 2*3 per edge
    @(negedge clk);
    a = 16'd2; b = 16'd3; c = 16'd0; d = 16'd0; ce = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("acc_step%0d", i), o_acc, 32'(6 * i));
    end
    @(negedge clk); oload = 2'b11; d = 16'd5;
    @(posedge clk); #1; check("acc_load", o_acc, 32'd5);
    @(negedge clk); oload = 2'b00;
    @(posedge clk); #1; check("acc_after_load", o_acc, 32'd11);
    @(negedge clk); ohold = 2'b11;
    @(posedge clk); #1; check("acc_hold", o_acc, 32'd11);
    @(negedge clk); oload = 2'b11;
    @(posedge clk); #1; check("acc_hold_over_load", o_acc, 32'd11);
    @(negedge clk); ohold = 2'b00; oload = 2'b00;
    @(posedge clk); #1; check("acc_resume", o_acc, 32'd17);
    @(negedge clk); rst = 1'b1;
    #1;
    check("acc_async_rst", o_acc, 32'd0);
    check("reg_async_rst", o_reg, 32'd0);
    #1; rst = 1'b0;
    @(posedge clk); #1; check("acc_after_rst", o_acc, 32'd6);
    @(negedge clk); ce = 1'b0;
    @(posedge clk); #1; check("acc_ce_low", o_acc, 32'd6);

    // Pipelined multiply with input holds, scoreboarded
    @(negedge clk); rst = 1'b1; ce = 1'b1;
    #1; rst = 1'b0;
    a_mdl = '0; b_mdl = '0;
    sb_q.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom);
      ih = (i < 2) ? 2'b00 : 2'($urandom_range(0, 3));
      ihold = {ih, 2'b00};
      if (!ihold[3]) a_mdl = {16'd0, a};
      if (!ihold[2]) b_mdl = {16'd0, b};
      exp_p = a_mdl * b_mdl;
      sb_q.push_back('{exp_p, 1'b0});
      @(posedge clk); #1;
      if (sb_q.size() >= 2) begin
        e = sb_q.pop_front();
        check($sformatf("pipe_mul%0d", i - 1), o_reg, e.o);
      end
    end
    @(negedge clk); ihold = 4'b1100;
    @(posedge clk); #1;
    if (sb_q.size() != 1) begin
      checks++; failures++;
      $display("FAIL pipe_drain: queue size %0d expected 1", sb_q.size());
    end else begin
      e = sb_q.pop_front();
      check("pipe_mul_last", o_reg, e.o);
    end
    @(negedge clk); rst = 1'b1;
    #1; check("pipe_async_rst", o_reg, 32'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sb_mac16_core.md
SB_MAC16_CORE -- requirements
Module: sb_mac16_core

Interface
REQ-001 SHALL have parameter SIGNED, default 2'b00, meaning {A signed, B signed} for the multiplier.
REQ-002 SHALL have parameter IN_REG, default 4'b0000, meaning one register-enable bit per input, ordered {A,B,C,D}.
REQ-003 SHALL have parameter MULT_REG, default 1'b0, meaning a pipeline register on the multiplier products.
REQ-004 SHALL have parameter MODE_8X8, default 1'b0, meaning dual 8x8 multiply mode; ignored without the Configuration macro.
REQ-005 SHALL have parameter UPPERINPUT, default 2'b00, meaning the {top,bot} adder upper operand: 0 = accumulator Q, 1 = C (top) or D (bot).
REQ-006 SHALL have parameter LOWERINPUT, default 4'b0000, meaning the {top[1:0],bot[1:0]} adder lower operand select.
REQ-007 SHALL have parameter CARRYSELECT, default 4'b0000, meaning the {top[1:0],bot[1:0]} adder carry-in select.
REQ-008 SHALL have parameter OUTPUT_SELECT, default 4'b0000, meaning the {top[1:0],bot[1:0]} output source select.
REQ-009 SHALL have port clk, input, 1 bit: the only clock; all registers update on its rising edge.
REQ-010 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-011 SHALL have port ce, input, 1 bit: global clock enable for all registers.
REQ-012 SHALL have ports a, b, c, d, inputs, 16 bits each: data operands.
REQ-013 SHALL have port ihold, input, 4 bits: per-input register hold, ordered {A,B,C,D}.
REQ-014 SHALL have ports ohold and oload, inputs, 2 bits each, ordered {top,bot}: accumulator hold and accumulator load.
REQ-015 SHALL have port addsub, input, 2 bits, ordered {top,bot}: 0 = add, 1 = subtract.
REQ-016 SHALL have ports ci (input, 1 bit) carry-in, co (output, 1 bit) top-adder carry/borrow out, and o (output, 32 bits) = {top half, bottom half}.

Function
REQ-017 SHALL make each input Aq/Bq/Cq/Dq the raw port when its IN_REG bit is 0; otherwise a register loaded when ce=1 and its ihold bit is 0.
REQ-018 SHALL form P as the low 32 bits of Aq*Bq, sign-extending each operand per SIGNED; F = Aq[15:8]*Bq[15:8] and G = Aq[7:0]*Bq[7:0] (16 bits each, 8x8 mode only); with MULT_REG=1, P/F/G SHALL be registered (ce-gated), adding 1 cycle of latency.
REQ-019 SHALL take the top adder X from UPPERINPUT (Qtop or Cq) and Y from LOWERINPUT top: 00 Aq, 01 F, 10 P[31:16], 11 zero.
REQ-020 SHALL take the bottom adder X from UPPERINPUT (Qbot or Dq) and Y from LOWERINPUT bottom: 00 Bq, 01 G, 10 P[15:0], 11 zero.
REQ-021 SHALL select top carry-in as 00 -> 0, 01 -> 1, 10 -> bottom carry-out, 11 -> ci; bottom carry-in as 00 -> 0, 01 -> 1, 1x -> ci.
REQ-022 SHALL compute each half modulo 2^16: add = X+Y+cin with carry-out = bit 16; subtract = X-Y-cin with carry-out = borrow; co = top carry-out.
REQ-023 SHALL update Qtop/Qbot on a clock edge when ce=1 and ohold=0, taking Cq/Dq if oload=1, else the adder sum; when ohold=1, Q SHALL keep its value regardless of oload.
REQ-024 SHALL drive each output half per OUTPUT_SELECT: 00 combinational sum, 01 Q, 10 F (top) / G (bottom), 11 P[31:16] (top) / P[15:0] (bottom).
REQ-025 SHALL have zero latency from inputs to o for the all-combinational configuration.

Reset
REQ-026 SHALL clear all input, product and accumulator registers to 0 immediately when rst=1, with priority over ce, hold and load; o SHALL then reflect the cleared registers (0 for registered output paths).

Configuration
REQ-027 SHALL implement the 8x8 multipliers F/G only when MAC16_MODE8X8_EN is defined; without it, F = G = 0 and selects 01 (LOWERINPUT) and 10 (OUTPUT_SELECT) SHALL yield zero.

Structure
REQ-028 SHALL keep the select encodings (upper, lower, carry, output) as named constants in a shared package, sb_mac16_pkg.
REQ-029 SHALL instantiate a sub-module mac16_addsub16, one per half, each a 16-bit add/subtract with carry in and out.

Verification
REQ-030 SHALL check UPPERINPUT=11, LOWERINPUT=0000, CARRYSELECT=1000, OUTPUT_SELECT=0000, a=0001, b=FFFF, c=0000, d=0001 -> o=32'h00020000, co=0.
REQ-031 SHALL check LOWERINPUT=1010, UPPERINPUT=11, unsigned, a=b=FFFF, c=d=0 -> o=32'hFFFE0001; with SIGNED=11, a=FFFF, b=0002 -> o=32'hFFFFFFFE.
REQ-032 SHALL check addsub=11, UPPERINPUT=11, LOWERINPUT=0000, CARRYSELECT=1000, {c,d}=32'h00010000, {a,b}=32'h00000001 -> o=32'h0000FFFF, co=0.
REQ-033 SHALL check accumulate: UPPERINPUT=00, LOWERINPUT=1010, CARRYSELECT=1000, OUTPUT_SELECT=0101, a=2, b=3, ce=1 over 3 edges -> o=6, 12, 18; oload=11 with c=0, d=5 -> o=5.
REQ-034 SHALL check that asserting rst between clock edges during accumulation clears o to 0 immediately, and that ohold=11 freezes o.
